// File: rtl/reg_read_stage.sv
// Register-read stage: drives the register file read selects, aligns the 1-cycle read data with the payload,
// bypasses writeback, and holds operands across stalls. Define OPT_REG_READ_STATS_EN to add the stall/bypass counters.
//
// state | meaning
// EMPTY | no instruction held, out_valid low
// FRESH | instruction accepted last edge, operands come from the register file (or captured bypass)
// HELD  | stalled, operands live in the local hold registers
module reg_read_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int SEL_WIDTH     = 4,
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_WIDTH-1:0]     in_sel_ra,
  input  logic [SEL_WIDTH-1:0]     in_sel_rb,
  input  logic [SEL_WIDTH-1:0]     in_sel_rc,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic [SEL_WIDTH-1:0]     rf_read_sel_ra,
  output logic [SEL_WIDTH-1:0]     rf_read_sel_rb,
  output logic [SEL_WIDTH-1:0]     rf_read_sel_rc,
  input  logic [DATA_WIDTH-1:0]    rf_read_data_ra,
  input  logic [DATA_WIDTH-1:0]    rf_read_data_rb,
  input  logic [DATA_WIDTH-1:0]    rf_read_data_rc,
  input  logic                     wb_en,
  input  logic [SEL_WIDTH-1:0]     wb_sel,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data_ra,
  output logic [DATA_WIDTH-1:0]    out_data_rb,
  output logic [DATA_WIDTH-1:0]    out_data_rc,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
`ifdef OPT_REG_READ_STATS_EN
  ,
  output logic [31:0]              out_stat_stall_cycles,
  output logic [31:0]              out_stat_bypass_hits
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t                          state;
  logic                            accept;
  logic [2:0][SEL_WIDTH-1:0]       in_sel;
  logic [2:0][SEL_WIDTH-1:0]       sel_q;
  logic [2:0][DATA_WIDTH-1:0]      rf_data;
  logic [2:0][DATA_WIDTH-1:0]      byp_data_q;
  logic [2:0][DATA_WIDTH-1:0]      hold_q;
  logic [2:0][DATA_WIDTH-1:0]      operand;
  logic [2:0]                      byp_q;
  logic [2:0]                      wb_hit_in;
  logic [2:0]                      wb_hit_q;
  logic [PAYLOAD_WIDTH-1:0]        payload_q;

  assign rf_read_sel_ra = in_sel_ra;
  assign rf_read_sel_rb = in_sel_rb;
  assign rf_read_sel_rc = in_sel_rc;

  assign in_ready = (state == EMPTY) | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  assign out_data_ra = operand[0];
  assign out_data_rb = operand[1];
  assign out_data_rc = operand[2];
  assign out_payload = payload_q;

  always_comb begin
    in_sel[0]  = in_sel_ra;
    in_sel[1]  = in_sel_rb;
    in_sel[2]  = in_sel_rc;
    rf_data[0] = rf_read_data_ra;
    rf_data[1] = rf_read_data_rb;
    rf_data[2] = rf_read_data_rc;
  end

  // The register file returns pre-write data for a same-edge write, so hits are needed both at accept and while held.
  always_comb begin
    wb_hit_in = '0;
    wb_hit_q  = '0;
    operand   = '0;
    for (int p = 0; p < 3; p++) begin
      wb_hit_in[p] = wb_en & (wb_sel == in_sel[p]) & (in_sel[p] != '0);
      wb_hit_q[p]  = wb_en & (wb_sel == sel_q[p]) & (sel_q[p] != '0);
      if (sel_q[p] == '0)
        operand[p] = '0;
      else if (wb_hit_q[p])
        operand[p] = wb_data;
      else if (state == FRESH)
        operand[p] = byp_q[p] ? byp_data_q[p] : rf_data[p];
      else if (state == HELD)
        operand[p] = hold_q[p];
      else
        operand[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      sel_q      <= '0;
      payload_q  <= '0;
      byp_q      <= '0;
      byp_data_q <= '0;
      hold_q     <= '0;
    end else begin
      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state     <= FRESH;
              out_valid <= 1'b1;
            end
          end
          FRESH, HELD: begin
            if (out_ready) begin
              state     <= accept ? FRESH : EMPTY;
              out_valid <= accept;
            end else begin
              state     <= HELD;
              out_valid <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        endcase
      end

      if (accept) begin
        sel_q     <= in_sel;
        payload_q <= in_payload;
        byp_q     <= wb_hit_in;
        for (int p = 0; p < 3; p++)
          byp_data_q[p] <= wb_hit_in[p] ? wb_data : '0;
      end

      if (state == FRESH && !out_ready) begin
        hold_q <= operand;
      end else if (state == HELD) begin
        for (int p = 0; p < 3; p++)
          if (wb_hit_q[p])
            hold_q[p] <= wb_data;
      end
    end
  end

`ifdef OPT_REG_READ_STATS_EN
  logic any_wb_sel;

  always_comb begin
    any_wb_sel = 1'b0;
    for (int p = 0; p < 3; p++)
      if (sel_q[p] != '0 && (wb_hit_q[p] || (state == FRESH && byp_q[p])))
        any_wb_sel = 1'b1;
    any_wb_sel = any_wb_sel & out_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stat_stall_cycles <= '0;
      out_stat_bypass_hits  <= '0;
    end else begin
      if (out_valid && !out_ready && out_stat_stall_cycles != 32'hFFFF_FFFF)
        out_stat_stall_cycles <= out_stat_stall_cycles + 32'd1;
      if (any_wb_sel && out_stat_bypass_hits != 32'hFFFF_FFFF)
        out_stat_bypass_hits <= out_stat_bypass_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: register file model, architectural reference with scoreboard, scenario tasks.
module tb_reg_read_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel_ra, in_sel_rb, in_sel_rc;
  logic [63:0] in_payload;
  logic [3:0]  rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc;
  logic [31:0] rf_read_data_ra, rf_read_data_rb, rf_read_data_rc;
  logic        wb_en;
  logic [3:0]  wb_sel;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data_ra, out_data_rb, out_data_rc;
  logic [63:0] out_payload;
`ifdef OPT_REG_READ_STATS_EN
  logic [31:0] out_stat_stall_cycles;
  logic [31:0] out_stat_bypass_hits;
`endif

  int vectors = 0;
  int miscompares = 0;

  reg_read_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel_ra(in_sel_ra), .in_sel_rb(in_sel_rb), .in_sel_rc(in_sel_rc),
    .in_payload(in_payload),
    .rf_read_sel_ra(rf_read_sel_ra), .rf_read_sel_rb(rf_read_sel_rb), .rf_read_sel_rc(rf_read_sel_rc),
    .rf_read_data_ra(rf_read_data_ra), .rf_read_data_rb(rf_read_data_rb), .rf_read_data_rc(rf_read_data_rc),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_ra(out_data_ra), .out_data_rb(out_data_rb), .out_data_rc(out_data_rc),
    .out_payload(out_payload)
`ifdef OPT_REG_READ_STATS_EN
    ,
    .out_stat_stall_cycles(out_stat_stall_cycles),
    .out_stat_bypass_hits(out_stat_bypass_hits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read, write on the same edge, read returns pre-write data; r0 is hardwired zero.
  logic [31:0] rf [16] = '{32'h0, 32'h11, 32'h22, 32'h5, 32'h44, 32'h55, 32'h66, 32'h77,
                           32'h88, 32'h99, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 32'hEE, 32'hFF};
  always @(posedge clk) begin
    rf_read_data_ra <= rf[rf_read_sel_ra];
    rf_read_data_rb <= rf[rf_read_sel_rb];
    rf_read_data_rc <= rf[rf_read_sel_rc];
    if (wb_en && wb_sel != 4'd0) rf[wb_sel] <= wb_data;
  end

  // Architectural view: an operand equals the latest register value, including a write in the consume cycle.
  typedef struct packed {
    logic [2:0][3:0]  sel;
    logic [2:0][31:0] data;
    logic [63:0]      payload;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] arch [16] = '{32'h0, 32'h11, 32'h22, 32'h5, 32'h44, 32'h55, 32'h66, 32'h77,
                             32'h88, 32'h99, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 32'hEE, 32'hFF};
  logic        exp_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_ready = (q.size() == 0) || out_ready;
      if (wb_en && wb_sel != 4'd0) begin
        arch[wb_sel] = wb_data;
        for (int i = 0; i < q.size(); i++) begin
          e = q[i];
          for (int p = 0; p < 3; p++)
            if (e.sel[p] == wb_sel) e.data[p] = wb_data;
          q[i] = e;
        end
      end
      vectors++;
      if (out_valid !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL sb_out_valid t=%0t got=%b want=%b", $time, out_valid, q.size() != 0);
      end
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL sb_in_ready t=%0t got=%b want=%b", $time, in_ready, exp_ready);
      end
      if (q.size() != 0 && out_ready && !flush) begin
        e = q.pop_front();
        vectors++;
        if ({out_data_rc, out_data_rb, out_data_ra} !== e.data || out_payload !== e.payload) begin
          miscompares++;
          $display("FAIL sb_result t=%0t got=%h/%h/%h pl=%h want=%h/%h/%h pl=%h", $time,
                   out_data_ra, out_data_rb, out_data_rc, out_payload,
                   e.data[0], e.data[1], e.data[2], e.payload);
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && exp_ready) begin
        e.sel[0] = in_sel_ra; e.sel[1] = in_sel_rb; e.sel[2] = in_sel_rc;
        e.data[0] = arch[in_sel_ra]; e.data[1] = arch[in_sel_rb]; e.data[2] = arch[in_sel_rc];
        e.payload = in_payload;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [63:0] pl);
    in_valid = v; in_sel_ra = a; in_sel_rb = b; in_sel_rc = c; in_payload = pl;
  endtask

  task automatic drive_wb(input logic en, input logic [3:0] s, input logic [31:0] d);
    wb_en = en; wb_sel = s; wb_data = d;
  endtask

  task automatic test_reset();
    tick();
    tick();
    in_sel_ra = 4'd7;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_payload !== 64'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ctrl got v=%b pl=%h rdy=%b want v=0 pl=0 rdy=1", out_valid, out_payload, in_ready);
    end
    vectors++;
    if (out_data_ra !== 32'h0 || out_data_rb !== 32'h0 || out_data_rc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h/%h/%h want 0/0/0", out_data_ra, out_data_rb, out_data_rc);
    end
    vectors++;
    if (rf_read_sel_ra !== 4'd7) begin
      miscompares++;
      $display("FAIL sel_passthru got %0d want 7", rf_read_sel_ra);
    end
    in_sel_ra = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive_in(1'b1, 4'd1, 4'd2, 4'd0, 64'h1);
    tick();
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data_ra !== 32'h11 || out_data_rb !== 32'h22 || out_data_rc !== 32'h0) begin
      miscompares++;
      $display("FAIL basic got v=%b %h/%h/%h want 1 11/22/0", out_valid, out_data_ra, out_data_rb, out_data_rc);
    end
    tick();
  endtask

  task automatic test_accept_bypass();
    drive_in(1'b1, 4'd3, 4'd0, 4'd0, 64'h2);
    drive_wb(1'b1, 4'd3, 32'hDEAD);
    tick();
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
    drive_wb(1'b0, 4'd0, 32'h0);
    @(negedge clk);
    vectors++;
    if (out_data_ra !== 32'hDEAD) begin
      miscompares++;
      $display("FAIL accept_bypass got %h want dead", out_data_ra);
    end
    tick();
  endtask

  task automatic test_stall_wb();
    out_ready = 1'b0;
    drive_in(1'b1, 4'd1, 4'd2, 4'd4, 64'h5);
    tick();
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_rdy1 got %b want 0", in_ready);
    end
    tick();
    drive_wb(1'b1, 4'd2, 32'hBEEF);
    @(negedge clk);
    vectors++;
    if (out_data_rb !== 32'hBEEF || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_live got rb=%h rdy=%b want beef 0", out_data_rb, in_ready);
    end
    tick();
    drive_wb(1'b0, 4'd0, 32'h0);
    @(negedge clk);
    vectors++;
    if (out_data_ra !== 32'h11 || out_data_rb !== 32'hBEEF || out_data_rc !== 32'h44 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_held got %h/%h/%h rdy=%b want 11/beef/44 0",
               out_data_ra, out_data_rb, out_data_rc, in_ready);
    end
    tick();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] pls [3];
    pls[0] = 64'hA; pls[1] = 64'hB; pls[2] = 64'hC;
    drive_in(1'b1, 4'd1, 4'd2, 4'd3, pls[0]);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive_in(1'b1, 4'd4, 4'd0, 4'd1, pls[1]);
      else if (i == 1) drive_in(1'b1, 4'd2, 4'd2, 4'd2, pls[2]);
      else drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_payload !== pls[i]) begin
        miscompares++;
        $display("FAIL b2b_%0d got v=%b pl=%h want 1 %h", i, out_valid, out_payload, pls[i]);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain got %b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_flush_r0();
    out_ready = 1'b0;
    drive_in(1'b1, 4'd0, 4'd1, 4'd0, 64'hF);
    tick();
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
    tick();
    drive_wb(1'b1, 4'd0, 32'h1234);
    @(negedge clk);
    vectors++;
    if (out_data_ra !== 32'h0 || out_data_rb !== 32'h11) begin
      miscompares++;
      $display("FAIL wb_r0 got ra=%h rb=%h want 0 11", out_data_ra, out_data_rb);
    end
    tick();
    drive_wb(1'b0, 4'd0, 32'h0);
    out_ready = 1'b1;
    flush = 1'b1;
    drive_in(1'b1, 4'd3, 4'd0, 4'd0, 64'hE);
    tick();
    flush = 1'b0;
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush got v=%b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    drive_in(1'b1, 4'd1, 4'd2, 4'd3, 64'h7);
    tick();
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data_ra !== 32'h0 || out_payload !== 64'h0) begin
      miscompares++;
      $display("FAIL async_reset got v=%b ra=%h pl=%h want 0 0 0", out_valid, out_data_ra, out_payload);
    end
`ifdef OPT_REG_READ_STATS_EN
    vectors++;
    if (out_stat_stall_cycles !== 32'd0 || out_stat_bypass_hits !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_reset got %0d/%0d want 0/0", out_stat_stall_cycles, out_stat_bypass_hits);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    drive_in(1'b1, 4'd5, 4'd6, 4'd7, 64'h9);
    tick();
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
    repeat (5) tick();
`ifdef OPT_REG_READ_STATS_EN
    vectors++;
    if (out_stat_stall_cycles !== 32'd5) begin
      miscompares++;
      $display("FAIL stats_stall got %0d want 5", out_stat_stall_cycles);
    end
`endif
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 64'h0);
    drive_wb(1'b0, 4'd0, 32'h0);
    test_reset();
    test_basic();
    test_accept_bypass();
    test_stall_wb();
    test_back_to_back();
    test_flush_r0();
    test_reset_mid_stall();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover got %0d entries want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
